// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, encodings and helpers for the configurable
//               UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Divisors below this are replaced by the build-time default divisor.
  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Mask of the data bits actually transmitted for a given length encoding.
  function automatic logic [7:0] data_mask(input logic [1:0] bits_enc);
    case (bits_enc)
      DBITS_5: return 8'h1F;
      DBITS_6: return 8'h3F;
      DBITS_7: return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Index of the last data bit: encoding 00..11 maps to 4..7.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits_enc);
    return {1'b1, bits_enc};
  endfunction

  // Parity bit over the transmitted data bits only.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] bits_enc,
                                      input parity_t    par);
    logic x;
    x = ^(data & data_mask(bits_enc));
    case (par)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock show-ahead FIFO with occupancy output. The head
//               entry is always visible on pop_data while not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             do_push,  do_pop;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; requests against full/empty are dropped.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers; reset flushes the FIFO by clearing pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_cfg
// Description : FIFO-buffered UART transmitter with runtime baud divisor and
//               frame format (5-8 data bits, none/even/odd/mark parity,
//               1 or 2 stop bits). Frames run back-to-back while data waits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK      = 50_000_000,
  parameter int DEF_DIV    = CLOCK / 115200,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_data_vld,
  output logic             tx_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [LVL_W-1:0] fifo_level
);

  state_t           state_q,   state_d;
  logic [DIV_W-1:0] baud_q,    baud_d;
  logic [2:0]       bit_q,     bit_d;
  logic [7:0]       shift_q,   shift_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [1:0]       dbits_q,   dbits_d;
  parity_t          parity_q,  parity_d;
  logic             stop2_q,   stop2_d;
  logic             par_bit_q, par_bit_d;
  logic             tx_q,      tx_d;
  logic             tx_done_q, tx_done_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic [DIV_W-1:0] eff_div;
  logic             baud_wrap;
  logic             stop_last;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_data_vld && tx_ready;
  assign eff_div   = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(DEF_DIV) : cfg_div;
  assign baud_wrap = (baud_q == div_q - DIV_W'(1));
  assign stop_last = (bit_q == {2'b00, stop2_q});

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q != ST_IDLE);

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Frame sequencer: next state, baud/bit counters, shifter and line value.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_d     = div_q;
    dbits_d   = dbits_q;
    parity_d  = parity_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
    tx_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fifo_pop = !fifo_empty;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == last_bit_idx(dbits_q)) begin
            bit_d   = '0;
            state_d = (parity_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      ST_PARITY: begin
        tx_d = par_bit_q;
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          baud_d = '0;
          if (stop_last) begin
            tx_done_d = 1'b1;
            bit_d     = '0;
            if (!fifo_empty) fifo_pop = 1'b1;
            else             state_d  = ST_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: take the head byte and freeze the format for this frame.
    if (fifo_pop) begin
      shift_d   = fifo_rd_data;
      div_d     = eff_div;
      dbits_d   = cfg_data_bits;
      parity_d  = parity_t'(cfg_parity);
      stop2_d   = cfg_stop2;
      par_bit_d = parity_bit(fifo_rd_data, cfg_data_bits, parity_t'(cfg_parity));
      baud_d    = '0;
      bit_d     = '0;
      state_d   = ST_START;
    end
  end

  // State and datapath registers; tx idles high and returns high on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      dbits_q   <= DBITS_8;
      parity_q  <= PAR_NONE;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      dbits_q   <= dbits_d;
      parity_q  <= parity_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule
`default_nettype wire
